// File: rtl/ctrl_pipe.sv
// ctrl_pipe
// Decodes a 5-bit opcode into a control bundle (mem_re, mem_we, reg_we) and a destination
// register. The bundle then moves through DEPTH pipeline stages, where stage 0 is the youngest.
// The pipe supports three more operations:
//   - a jump flushes the leading FLUSH_DEPTH stages;
//   - a stall holds stage 0 and puts a bubble into stage 1;
//   - a combinational load-use hazard flag is raised when stage 0 holds a load whose rd is a
//     source of the incoming instruction.
// A saturating counter tracks how many cycles had a jump.
//
// Parameters:
//   DEPTH        number of control stages (1..8)
//   FLUSH_DEPTH  leading stages cleared on jump (1..DEPTH)
//   LW_WB        1: lw also asserts reg_we; 0: lw leaves reg_we low
//   REGW         register index width
//   CNTW         flush counter width
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_opcode       incoming opcode
//   i_rd           incoming destination register
//   i_rs1, i_rs2   incoming source registers (hazard check only)
//   i_valid_in     incoming opcode valid; 0 decodes as a bubble
//   i_jump         flush request (overrides stall)
//   i_stall        hold request
//   o_mem_re       per-stage memory read enable, bit i = stage i
//   o_mem_we       per-stage memory write enable
//   o_reg_we       per-stage register write enable
//   o_rd_q         per-stage rd, stage i at [i*REGW +: REGW]
//   o_load_use     combinational load-use hazard
//   o_flush_cnt    saturating count of jump cycles

module ctrl_pipe #(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned LW_WB       = 0,
  parameter int unsigned REGW        = 5,
  parameter int unsigned CNTW        = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_opcode,
  input  logic [REGW-1:0]        i_rd,
  input  logic [REGW-1:0]        i_rs1,
  input  logic [REGW-1:0]        i_rs2,
  input  logic                   i_valid_in,
  input  logic                   i_jump,
  input  logic                   i_stall,
  output logic [DEPTH-1:0]       o_mem_re,
  output logic [DEPTH-1:0]       o_mem_we,
  output logic [DEPTH-1:0]       o_reg_we,
  output logic [DEPTH*REGW-1:0]  o_rd_q,
  output logic                   o_load_use,
  output logic [CNTW-1:0]        o_flush_cnt
);

  // Opcode map
  localparam logic [4:0] OpLw   = 5'b10100;
  localparam logic [4:0] OpSw   = 5'b10101;
  localparam logic [4:0] OpAlu0 = 5'b01100;
  localparam logic [4:0] OpAlu1 = 5'b01101;
  localparam logic [4:0] OpAlu2 = 5'b01110;
  localparam logic [4:0] OpAlu3 = 5'b01000;
  localparam logic [4:0] OpAlu4 = 5'b00110;
  localparam logic [4:0] OpAlu5 = 5'b01001;
  localparam logic [4:0] OpAlu6 = 5'b00101;
  localparam logic [4:0] OpAlu7 = 5'b00100;

  // Pipeline state
  logic [DEPTH-1:0]      r_mem_re;
  logic [DEPTH-1:0]      r_mem_we;
  logic [DEPTH-1:0]      r_reg_we;
  logic [DEPTH*REGW-1:0] r_rd;
  logic [CNTW-1:0]       r_flush_cnt;

  // Decoder outputs for the incoming instruction
  logic            w_dec_re;
  logic            w_dec_we;
  logic            w_dec_rw;
  logic [REGW-1:0] w_dec_rd;

  // Stage masks, fixed by parameters
  logic [DEPTH-1:0]      w_flush_mask;    // stages cleared by a jump
  logic [DEPTH*REGW-1:0] w_rd_flush_mask;
  logic [DEPTH-1:0]      w_stall_clr;     // stage 1 takes a bubble while stalled
  logic [DEPTH*REGW-1:0] w_rd_stall_clr;
  logic [DEPTH-1:0]      w_stage0;        // stage 0 holds while stalled
  logic [DEPTH*REGW-1:0] w_rd_stage0;

  // Advanced view of the pipe: every stage takes stage i-1, and stage 0 takes a bubble
  logic [DEPTH-1:0]      w_shift_re;
  logic [DEPTH-1:0]      w_shift_we;
  logic [DEPTH-1:0]      w_shift_rw;
  logic [DEPTH*REGW-1:0] w_shift_rd;

  // Decode placed at stage 0, all other stages zero
  logic [DEPTH-1:0]      w_ins_re;
  logic [DEPTH-1:0]      w_ins_we;
  logic [DEPTH-1:0]      w_ins_rw;
  logic [DEPTH*REGW-1:0] w_ins_rd;

  // Next state
  logic [DEPTH-1:0]      w_mem_re_d;
  logic [DEPTH-1:0]      w_mem_we_d;
  logic [DEPTH-1:0]      w_reg_we_d;
  logic [DEPTH*REGW-1:0] w_rd_d;
  logic [CNTW-1:0]       w_flush_cnt_d;

  logic [REGW-1:0] w_rd0;
  logic            w_cnt_max;

  // Decoder. An invalid slot becomes a bubble, and its rd is cleared too.
  always_comb begin
    w_dec_re = 1'b0;
    w_dec_we = 1'b0;
    w_dec_rw = 1'b0;
    if (i_valid_in) begin
      case (i_opcode)
        OpLw: begin
          w_dec_re = 1'b1;
          w_dec_rw = (LW_WB != 0);
        end
        OpSw: w_dec_we = 1'b1;
        OpAlu0, OpAlu1, OpAlu2, OpAlu3,
        OpAlu4, OpAlu5, OpAlu6, OpAlu7: w_dec_rw = 1'b1;
        default: ; // jal, beq and unknown opcodes carry no control
      endcase
    end
  end

  assign w_dec_rd = i_valid_in ? i_rd : '0;

  // Per-stage masks
  always_comb begin
    w_flush_mask    = '0;
    w_rd_flush_mask = '0;
    w_stall_clr     = '0;
    w_rd_stall_clr  = '0;
    w_stage0        = '0;
    w_rd_stage0     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_flush_mask[i]                  = (i < FLUSH_DEPTH);
      w_rd_flush_mask[i*REGW +: REGW]  = {REGW{(i < FLUSH_DEPTH)}};
      w_stall_clr[i]                   = (i == 1);
      w_rd_stall_clr[i*REGW +: REGW]   = {REGW{(i == 1)}};
      w_stage0[i]                      = (i == 0);
      w_rd_stage0[i*REGW +: REGW]      = {REGW{(i == 0)}};
    end
  end

  // The shift drops stage DEPTH-1. A zero shifts into stage 0, and that zero is a bubble.
  assign w_shift_re = r_mem_re << 1;
  assign w_shift_we = r_mem_we << 1;
  assign w_shift_rw = r_reg_we << 1;
  assign w_shift_rd = r_rd << REGW;

  always_comb begin
    w_ins_re              = '0;
    w_ins_we              = '0;
    w_ins_rw              = '0;
    w_ins_rd              = '0;
    w_ins_re[0]           = w_dec_re;
    w_ins_we[0]           = w_dec_we;
    w_ins_rw[0]           = w_dec_rw;
    w_ins_rd[REGW-1:0]    = w_dec_rd;
  end

  // Next-state select in priority order: jump, then stall, then normal advance.
  always_comb begin
    w_mem_re_d = r_mem_re;
    w_mem_we_d = r_mem_we;
    w_reg_we_d = r_reg_we;
    w_rd_d     = r_rd;
    if (i_jump) begin
      // Stage FLUSH_DEPTH-1 (the jump) moves on to stage FLUSH_DEPTH; the decode is discarded
      w_mem_re_d = w_shift_re & ~w_flush_mask;
      w_mem_we_d = w_shift_we & ~w_flush_mask;
      w_reg_we_d = w_shift_rw & ~w_flush_mask;
      w_rd_d     = w_shift_rd & ~w_rd_flush_mask;
    end else if (i_stall) begin
      // Stage 0 holds. A bubble goes into stage 1, and the older stages keep draining.
      w_mem_re_d = (w_shift_re & ~w_stall_clr) | (r_mem_re & w_stage0);
      w_mem_we_d = (w_shift_we & ~w_stall_clr) | (r_mem_we & w_stage0);
      w_reg_we_d = (w_shift_rw & ~w_stall_clr) | (r_reg_we & w_stage0);
      w_rd_d     = (w_shift_rd & ~w_rd_stall_clr) | (r_rd & w_rd_stage0);
    end else begin
      w_mem_re_d = w_shift_re | w_ins_re;
      w_mem_we_d = w_shift_we | w_ins_we;
      w_reg_we_d = w_shift_rw | w_ins_rw;
      w_rd_d     = w_shift_rd | w_ins_rd;
    end
  end

  // Saturating jump counter
  assign w_cnt_max     = &r_flush_cnt;
  assign w_flush_cnt_d = (i_jump && !w_cnt_max) ? r_flush_cnt + CNTW'(1) : r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem_re    <= '0;
      r_mem_we    <= '0;
      r_reg_we    <= '0;
      r_rd        <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_mem_re    <= w_mem_re_d;
      r_mem_we    <= w_mem_we_d;
      r_reg_we    <= w_reg_we_d;
      r_rd        <= w_rd_d;
      r_flush_cnt <= w_flush_cnt_d;
    end
  end

  // Load-use: the load in stage 0 writes a register that the incoming instruction reads.
  // x0 never counts as a hazard.
  assign w_rd0      = r_rd[REGW-1:0];
  assign o_load_use = i_valid_in & r_mem_re[0] & (w_rd0 != '0) &
                      ((w_rd0 == i_rs1) | (w_rd0 == i_rs2));

  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_reg_we    = r_reg_we;
  assign o_rd_q      = r_rd;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe. It drives two instances from the same inputs:
//   A: DEPTH=3, FLUSH_DEPTH=2, LW_WB=0, CNTW=2
//   B: DEPTH=3, FLUSH_DEPTH=1, LW_WB=1, CNTW=8
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] opcode = '0;
  logic [4:0] rd = '0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic       valid_in = 1'b0;
  logic       jump = 1'b0;
  logic       stall = 1'b0;

  logic [2:0]  a_re, a_we, a_rw, b_re, b_we, b_rw;
  logic [14:0] a_rd, b_rd;
  logic        a_lu, b_lu;
  logic [1:0]  a_cnt;
  logic [7:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ctrl_pipe #(.DEPTH(3), .FLUSH_DEPTH(2), .LW_WB(0), .REGW(5), .CNTW(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_valid_in(valid_in), .i_jump(jump), .i_stall(stall),
    .o_mem_re(a_re), .o_mem_we(a_we), .o_reg_we(a_rw), .o_rd_q(a_rd),
    .o_load_use(a_lu), .o_flush_cnt(a_cnt)
  );

  ctrl_pipe #(.DEPTH(3), .FLUSH_DEPTH(1), .LW_WB(1), .REGW(5), .CNTW(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2),
    .i_valid_in(valid_in), .i_jump(jump), .i_stall(stall),
    .o_mem_re(b_re), .o_mem_we(b_we), .o_reg_we(b_rw), .o_rd_q(b_rd),
    .o_load_use(b_lu), .o_flush_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  // Record fields: {mem_re, mem_we, reg_we, rd}
  typedef struct {
    logic [4:0] op;
    logic       v;
    logic [4:0] rd;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];

  function automatic logic [7:0] ent_a(input int i);
    return {a_re[i], a_we[i], a_rw[i], a_rd[i*5 +: 5]};
  endfunction

  function automatic logic [7:0] ent_b(input int i);
    return {b_re[i], b_we[i], b_rw[i], b_rd[i*5 +: 5]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns 1 time unit after the rising edge, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic v, input logic [4:0] r);
    opcode   = op;
    valid_in = v;
    rd       = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0; jump = 1'b0; stall = 1'b0; rs1 = '0; rs2 = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] sat_a [5];
    sat_a = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    vecs[0]  = '{5'b01101, 1'b1, 5'd7,  {3'b001, 5'd7},  {3'b001, 5'd7}};
    vecs[1]  = '{5'b10100, 1'b1, 5'd3,  {3'b100, 5'd3},  {3'b101, 5'd3}};
    vecs[2]  = '{5'b10101, 1'b1, 5'd4,  {3'b010, 5'd4},  {3'b010, 5'd4}};
    vecs[3]  = '{5'b10000, 1'b1, 5'd9,  {3'b000, 5'd9},  {3'b000, 5'd9}};
    vecs[4]  = '{5'b11111, 1'b1, 5'd10, {3'b000, 5'd10}, {3'b000, 5'd10}};
    vecs[5]  = '{5'b01100, 1'b1, 5'd1,  {3'b001, 5'd1},  {3'b001, 5'd1}};
    vecs[6]  = '{5'b00100, 1'b1, 5'd2,  {3'b001, 5'd2},  {3'b001, 5'd2}};
    vecs[7]  = '{5'b01101, 1'b0, 5'd5,  {3'b000, 5'd0},  {3'b000, 5'd0}};
    vecs[8]  = '{5'b10001, 1'b1, 5'd6,  {3'b000, 5'd6},  {3'b000, 5'd6}};
    vecs[9]  = '{5'b01000, 1'b1, 5'd31, {3'b001, 5'd31}, {3'b001, 5'd31}};
    vecs[10] = '{5'b00110, 1'b1, 5'd12, {3'b001, 5'd12}, {3'b001, 5'd12}};
    vecs[11] = '{5'b01001, 1'b1, 5'd13, {3'b001, 5'd13}, {3'b001, 5'd13}};
    vecs[12] = '{5'b00101, 1'b1, 5'd14, {3'b001, 5'd14}, {3'b001, 5'd14}};
    vecs[13] = '{5'b00111, 1'b1, 5'd15, {3'b000, 5'd15}, {3'b000, 5'd15}};

    // Reset: outputs zero while rst is held, even with a load-use-looking input
    #1 rst = 1'b1;
    drive(5'b10100, 1'b1, 5'd5);
    rs1 = 5'd5;
    #1;
    chk("rst_a_ctrl", {a_re, a_we, a_rw}, 9'd0);
    chk("rst_b_rd", b_rd, 15'd0);
    chk("rst_lu", {a_lu, b_lu}, 2'b00);
    tick();
    tick();
    chk("rst_held_a", {a_re, a_we, a_rw, a_rd, a_cnt}, 26'd0);
    chk("rst_held_b", {b_re, b_we, b_rw, b_rd, b_cnt}, 32'd0);
    do_reset();

    // Table: back-to-back decodes. The scoreboard is checked at stages 0, 1 and 2.
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].op, vecs[k].v, vecs[k].rd);
      sb.push_back(vecs[k]);
      tick();
      chk($sformatf("dec%0d_a_s0", k), ent_a(0), sb[$].exp_a);
      chk($sformatf("dec%0d_b_s0", k), ent_b(0), sb[$].exp_b);
      if (sb.size() >= 2) begin
        chk($sformatf("dec%0d_a_s1", k), ent_a(1), sb[sb.size()-2].exp_a);
      end
      if (sb.size() == 3) begin
        chk($sformatf("dec%0d_a_s2", k), ent_a(2), sb[0].exp_a);
        chk($sformatf("dec%0d_b_s2", k), ent_b(2), sb[0].exp_b);
        void'(sb.pop_front());
      end
    end

    // Jump with stall: pipe holds lw/sw/add in stages 0/1/2
    do_reset();
    drive(5'b01101, 1'b1, 5'd1); tick();
    drive(5'b10101, 1'b1, 5'd2); tick();
    drive(5'b10100, 1'b1, 5'd3); tick();
    drive(5'b01101, 1'b1, 5'd8);
    jump = 1'b1; stall = 1'b1;
    tick();
    chk("jmp_a_ctrl", {a_re, a_we, a_rw}, {3'b000, 3'b100, 3'b000});
    chk("jmp_a_rd", a_rd, {5'd2, 5'd0, 5'd0});
    chk("jmp_b_ctrl", {b_re, b_we, b_rw}, {3'b010, 3'b100, 3'b010});
    chk("jmp_b_rd", b_rd, {5'd2, 5'd3, 5'd0});
    chk("jmp_a_cnt", a_cnt, 2'd1);
    chk("jmp_b_cnt", b_cnt, 8'd1);

    // Jump held: the 2-bit counter saturates
    stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("sat%0d_a", k), a_cnt, sat_a[k]);
      chk($sformatf("sat%0d_b", k), b_cnt, 8'(k + 2));
    end
    chk("sat_a_bubbles", {a_re, a_we, a_rw, a_rd}, 24'd0);
    jump = 1'b0;

    // Stall with load-use: stage 0 = lw rd5, stage 1 = sw rd4
    do_reset();
    drive(5'b10101, 1'b1, 5'd4); tick();
    drive(5'b10100, 1'b1, 5'd5); tick();
    drive(5'b01101, 1'b1, 5'd9);
    rs1 = 5'd5; rs2 = 5'd0; stall = 1'b1;
    #1;
    chk("lu_a", a_lu, 1'b1);
    chk("lu_b", b_lu, 1'b1);
    tick();
    chk("stall1_re", a_re, 3'b001);
    chk("stall1_we", a_we, 3'b100);
    chk("stall1_rd", a_rd, {5'd4, 5'd0, 5'd5});
    tick();
    chk("stall2_re", a_re, 3'b001);
    chk("stall2_we", a_we, 3'b000);
    chk("stall2_rd", a_rd, {5'd0, 5'd0, 5'd5});
    chk("stall2_lu", a_lu, 1'b1);
    rs1 = 5'd6; rs2 = 5'd7;
    #1;
    chk("lu_nomatch", a_lu, 1'b0);
    rs2 = 5'd5; valid_in = 1'b0;
    #1;
    chk("lu_invalid", a_lu, 1'b0);
    valid_in = 1'b1; stall = 1'b0;
    tick();
    chk("unstall_a", {a_re, a_we, a_rw}, {3'b010, 3'b000, 3'b001});
    chk("unstall_rd", a_rd, {5'd0, 5'd5, 5'd9});

    // A load to rd=0 never raises load-use
    do_reset();
    drive(5'b10100, 1'b1, 5'd0); tick();
    rs1 = 5'd0; rs2 = 5'd0;
    drive(5'b01101, 1'b1, 5'd3);
    #1;
    chk("lu_rd0_re", a_re[0], 1'b1);
    chk("lu_rd0", {a_lu, b_lu}, 2'b00);

    // Async reset between edges with a full pipe
    tick(); tick(); tick();
    chk("full_rw", a_rw, 3'b111);
    #3 rst = 1'b1;
    #1;
    chk("async_a", {a_re, a_we, a_rw, a_rd}, 24'd0);
    chk("async_b", {b_re, b_we, b_rw, b_rd}, 24'd0);
    #1 rst = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("post_rst_bubble", {a_re, a_we, a_rw, a_rd}, 24'd0);
    drive(5'b01101, 1'b1, 5'd3);
    tick();
    chk("post_rst_adv", ent_a(0), {3'b001, 5'd3});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised successor to the single-stage opcode decoder. Decodes the 5-bit opcode into the control bundle (mem_re, mem_we, reg_we) plus destination register, and carries it through DEPTH pipeline stages. Supports jump flush of the leading stages, stall with bubble insertion, a load-use hazard flag, and a saturating flush counter. Sits between the fetch/decode front end and the EX/MEM/WB datapath stages.

## Interface
- DEPTH, 3: number of control stages (1..8); stage 0 is the youngest.
- FLUSH_DEPTH, 1: leading stages cleared on jump (1..DEPTH).
- LW_WB, 0: 1 makes lw also assert reg_we; 0 keeps lw reg_we=0.
- REGW, 5: register index width.
- CNTW, 8: flush counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  5  incoming instruction opcode.
- rd  in  REGW  incoming destination register.
- rs1, rs2  in  REGW each  incoming source registers (hazard check only).
- valid_in  in  1  incoming opcode valid; 0 decodes as bubble.
- jump  in  1  flush request.
- stall  in  1  hold request.
- mem_re, mem_we, reg_we  out  DEPTH each  per-stage control bits; bit i = stage i.
- rd_q  out  DEPTH*REGW  per-stage rd; stage i at bits [i*REGW +: REGW].
- load_use  out  1  combinational load-use hazard.
- flush_cnt  out  CNTW  saturating count of jump cycles.

## Operation
- Decode:
  - 10100 (lw): mem_re=1; reg_we=LW_WB.
  - 10101 (sw): mem_we=1.
  - 01100, 01101, 01110, 01000, 00110, 01001, 00101, 00100: reg_we=1.
  - 10000 (jal), 10001 (beq) and all other opcodes: all zero.
  - valid_in=0 forces all-zero and rd=0.
- A bubble is an entry with all control bits 0 and rd 0.
- Next-state, evaluated per cycle in priority order:
  - jump=1 (stall ignored): stages 0..FLUSH_DEPTH-1 become bubbles. Each stage i≥FLUSH_DEPTH takes stage i-1, so the instruction in stage FLUSH_DEPTH-1 (the jump itself) survives. The incoming decode is discarded.
  - stall=1: stage 0 holds. Stage 1 takes a bubble. Stages ≥2 take stage i-1. If DEPTH=1, stage 0 holds only.
  - Otherwise: stage 0 takes the decode; stage i takes stage i-1.
- Stage DEPTH-1 content is dropped on advance.
- load_use = valid_in & mem_re[0] & (rd_q stage 0 ≠ 0) & (rd_q stage 0 == rs1 or rd_q stage 0 == rs2). Purely combinational; the block never self-stalls, and the upstream unit drives stall.
- flush_cnt increments by 1 on every cycle with jump=1 and saturates at 2^CNTW-1.

## Timing
- Reset: all mem_re/mem_we/reg_we/rd_q = 0 and flush_cnt = 0 immediately on rst rise, held while rst=1. load_use = 0 during reset because mem_re[0]=0.
- Latency: opcode sampled at edge N appears on stage 0 after edge N, and on stage k after edge N+k absent stalls/jumps.
- Jump takes effect at the same edge it is sampled; there is no cycle of wrong-path control in the flushed stages afterwards.
- Stall held for M cycles inserts M bubbles into stage 1; stage 0 is unchanged throughout.
- Reset mid-operation discards all in-flight entries. The first edge after rst falls behaves as a normal advance from an all-bubble state.
- Saturated flush_cnt stays at max until reset; no wrap-around.

## Test plan
- Reset/decode: rst pulse, then valid_in=1 opcode 01101 rd=7 → after 1 edge reg_we[0]=1, rd_q stage0=7. After 2 more edges reg_we[2]=1 (DEPTH=3). All outputs 0 during rst.
- Modes: opcode 10100 with LW_WB=0 → mem_re[0]=1, reg_we[0]=0. LW_WB=1 → reg_we[0]=1. Opcode 10101 → mem_we[0]=1. Opcodes 10000, 11111 and valid_in=0 → all zero.
- Jump flush: FLUSH_DEPTH=2, stages hold add/sw/lw, jump=1 with stall=1 → next cycle stages 0,1 bubbles, stage 2 = old stage 1 (sw), flush_cnt=1.
- Stall: lw rd=5 in stage 0, incoming add rs1=5 → load_use=1. Stall 2 cycles → stage 0 stays lw, two bubbles appear in stage 1 then stage 2. With rd=0, load_use=0.
- Saturation: CNTW=2, jump held 6 cycles → flush_cnt 1,2,3,3,3,3.
- Async reset mid-stream: rst asserted between edges with a full pipe → outputs 0 before the next clk edge.
